// File: rtl/serial_rx_pkg.sv
// Shared definitions for the serial receive path: frame defaults and FSM state encoding.
package serial_rx_pkg;

    // Frame geometry shared with the transmit side.
    localparam int N_DEFAULT  = 8;
    localparam int OS_DEFAULT = 4;

    // Receiver FSM states.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BREAK = 3'd4
    } rx_state_t;

endpackage

// File: rtl/serial_rx_bit_timer.sv
// Oversampling bit timer: produces one tick per sample instant. After a restart with
// 'half' set, the first tick lands half a bit period in (the start-bit midpoint); later
// ticks are one full bit period apart.
module rx_bit_timer
    import serial_rx_pkg::*;
#(
    parameter int OS = OS_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic restart,
    input  logic half,
    output logic tick
);

    localparam int CW = (OS > 1) ? $clog2(OS) : 1;
    localparam logic [CW-1:0] HALF_LAST = CW'(OS / 2 - 1);
    localparam logic [CW-1:0] FULL_LAST = CW'(OS - 1);

    logic [CW-1:0] cnt_r;
    logic          half_r;
    logic [CW-1:0] last_s;

    // Terminal count depends on whether we are in the initial half-period.
    always_comb begin
        last_s = FULL_LAST;
        if (half_r) begin
            last_s = HALF_LAST;
        end else begin
            last_s = FULL_LAST;
        end
        tick = (cnt_r == last_s);
    end

    // Counter: restart wins, otherwise wrap to zero on each tick.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_r  <= {CW{1'b0}};
            half_r <= 1'b1;
        end else if (restart) begin
            cnt_r  <= {CW{1'b0}};
            half_r <= half;
        end else if (tick) begin
            cnt_r  <= {CW{1'b0}};
            half_r <= 1'b0;
        end else begin
            cnt_r  <= cnt_r + CW'(1);
        end
    end

endmodule

// File: rtl/serial_rx.sv
// Frame deserializer: start-bit hunt, midpoint sampling, LSB-first shift, stop-bit check,
// and a one-entry valid/ready output buffer with framing/overrun error pulses.
module serial_rx
    import serial_rx_pkg::*;
#(
    parameter int N  = N_DEFAULT,
    parameter int OS = OS_DEFAULT
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         din,
    output logic [N-1:0] dout,
    output logic         valid,
    input  logic         ready,
    output logic         frame_err,
    output logic         overrun
);

    localparam int IW = $clog2(N + 1);
    localparam logic [IW-1:0] LAST_BIT = IW'(N - 1);

    rx_state_t     state_r, state_s;
    logic [IW-1:0] idx_r, idx_s;
    logic [N-1:0]  sh_r, sh_s;
    logic          restart_s;
    logic          tick_s;
    logic          complete_s;
    logic          ferr_s;

    // The timer is held cleared while idle so the detection cycle starts the half period.
    rx_bit_timer #(.OS(OS)) u_timer (
        .clk     (clk),
        .reset   (reset),
        .restart (restart_s),
        .half    (1'b1),
        .tick    (tick_s)
    );

    // FSM, bit index and shift register state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
            idx_r   <= {IW{1'b0}};
            sh_r    <= {N{1'b0}};
        end else begin
            state_r <= state_s;
            idx_r   <= idx_s;
            sh_r    <= sh_s;
        end
    end

    // Next-state logic; din only matters at ticks, or while idle / in break.
    always_comb begin
        state_s    = state_r;
        idx_s      = idx_r;
        sh_s       = sh_r;
        restart_s  = 1'b0;
        complete_s = 1'b0;
        ferr_s     = 1'b0;
        case (state_r)
            IDLE: begin
                restart_s = 1'b1;
                if (!din) begin
                    state_s = START;
                end else begin
                    state_s = IDLE;
                end
            end
            START: begin
                if (tick_s) begin
                    if (!din) begin
                        state_s = DATA;
                        idx_s   = {IW{1'b0}};
                    end else begin
                        state_s = IDLE;  // glitch, not a real start bit
                    end
                end else begin
                    state_s = START;
                end
            end
            DATA: begin
                if (tick_s) begin
                    sh_s = {din, sh_r[N-1:1]};
                    if (idx_r == LAST_BIT) begin
                        state_s = STOP;
                    end else begin
                        idx_s = idx_r + IW'(1);
                    end
                end else begin
                    state_s = DATA;
                end
            end
            STOP: begin
                if (tick_s) begin
                    if (din) begin
                        complete_s = 1'b1;
                        state_s    = IDLE;
                    end else begin
                        ferr_s  = 1'b1;
                        state_s = BREAK;
                    end
                end else begin
                    state_s = STOP;
                end
            end
            BREAK: begin
                if (din) begin
                    state_s = IDLE;
                end else begin
                    state_s = BREAK;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Output buffer: accept a completed word if empty or being drained this cycle,
    // otherwise drop it and flag overrun.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dout      <= {N{1'b0}};
            valid     <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            frame_err <= ferr_s;
            overrun   <= 1'b0;
            if (complete_s) begin
                if (!valid || ready) begin
                    dout  <= sh_r;
                    valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (valid && ready) begin
                valid <= 1'b0;
            end else begin
                valid <= valid;
            end
        end
    end

endmodule

// File: tb/tb_serial_rx.sv
// Scoreboard bench for serial_rx: a frame-level sender schedules each frame's completion
// by arithmetic; a negedge monitor applies the buffer rules and checks the DUT.
module tb_serial_rx;
    import serial_rx_pkg::*;

    localparam int N   = N_DEFAULT;
    localparam int OS  = OS_DEFAULT;
    localparam int LAT = OS / 2 + (N + 1) * OS;  // detection edge to stop-sample edge

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         din = 1'b1;
    logic         ready = 1'b0;
    logic [N-1:0] dout;
    logic         valid;
    logic         frame_err;
    logic         overrun;

    serial_rx #(.N(N), .OS(OS)) dut (
        .clk       (clk),
        .reset     (reset),
        .din       (din),
        .dout      (dout),
        .valid     (valid),
        .ready     (ready),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    int unsigned e = 0;  // index of the most recent rising edge
    always @(posedge clk) e <= e + 1;

    typedef struct {
        int unsigned  at;
        logic         good;
        logic [N-1:0] word;
    } frame_t;

    frame_t       sched[$];   // pending frame completions
    logic [N-1:0] exp_q[$];   // word expected in the output buffer
    int           n_cmp = 0;
    int           n_bad = 0;
    logic         m_valid = 1'b0;
    logic         m_ferr = 1'b0;
    logic         m_ovr = 1'b0;
    int           ready_mode = 0;
    int unsigned  force_edge = 0;
    logic         done = 1'b0;
    logic         final_done = 1'b0;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s at edge %0d: got %0h, expected %0h", name, e, act, expv);
        end
    endtask

    // Monitor and reference model
    always @(negedge clk) begin
        frame_t f;
        if (reset) begin
            sched.delete();
            exp_q.delete();
            m_valid = 1'b0;
            m_ferr  = 1'b0;
            m_ovr   = 1'b0;
            cmp("dout_reset", 32'(dout), 32'd0);
        end
        cmp("valid", 32'(valid), 32'(m_valid));
        cmp("frame_err", 32'(frame_err), 32'(m_ferr));
        cmp("overrun", 32'(overrun), 32'(m_ovr));
        if (m_valid && exp_q.size() > 0) cmp("dout", 32'(dout), 32'(exp_q[0]));
        if (!reset) begin
            // what the next rising edge does
            if (m_valid && ready && exp_q.size() > 0) void'(exp_q.pop_front());
            m_ferr = 1'b0;
            m_ovr  = 1'b0;
            if (sched.size() > 0 && sched[0].at == e + 1) begin
                f = sched.pop_front();
                if (f.good) begin
                    if (!m_valid || ready) begin
                        m_valid = 1'b1;
                        exp_q.push_back(f.word);
                    end else begin
                        m_ovr = 1'b1;
                    end
                end else begin
                    m_ferr = 1'b1;
                end
            end else if (m_valid && ready) begin
                m_valid = 1'b0;
            end
        end
        if (done && !final_done) begin
            cmp("drain", 32'(exp_q.size() + sched.size()), 32'd0);
            final_done = 1'b1;
        end
    end

    task automatic drive(input logic d);
        @(posedge clk);
        #1;
        din = d;
        if (force_edge == e + 1) ready = 1'b1;
        else case (ready_mode)
            0:       ready = 1'b0;
            1:       ready = 1'b1;
            default: ready = 1'($urandom_range(0, 1));
        endcase
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b1);
    endtask

    task automatic pulse_ready();
        @(posedge clk);
        #1;
        din   = 1'b1;
        ready = 1'b1;
    endtask

    task automatic send_frame(input logic [N-1:0] w, input logic stop, input int abort_at,
                              input logic force_rdy);
        logic [N+1:0] bits;
        int unsigned  t0;
        bits = {stop, w, 1'b0};
        t0 = 0;
        for (int k = 0; k < (N + 2) * OS; k++) begin
            if (abort_at > 0 && k == abort_at) begin
                @(posedge clk);
                #1;
                reset = 1'b1;
                din   = 1'b1;
                idle(3);
                reset = 1'b0;
                force_edge = 0;
                return;
            end
            drive(bits[k / OS]);
            if (k == 0) begin
                t0 = e + 1;
                sched.push_back('{at: t0 + LAT, good: stop, word: w});
                if (force_rdy) force_edge = t0 + LAT;
            end
        end
    endtask

    task automatic glitch(input int len);
        for (int i = 0; i < len; i++) drive(1'b0);
        idle(OS / 2 + 1);
    endtask

    initial begin
        idle(3);
        reset = 1'b0;
        idle(2);

        // 0xA5 held with ready low, then drained by a one-cycle ready
        send_frame(8'hA5, 1'b1, 0, 1'b0);
        idle(6);
        pulse_ready();
        idle(2);

        // one-cycle glitch, then 0x3C
        glitch(1);
        send_frame(8'h3C, 1'b1, 0, 1'b0);
        idle(2);
        pulse_ready();
        idle(2);

        // bad stop bit, line held low, then 0x42
        send_frame(8'h81, 1'b0, 0, 1'b0);
        for (int i = 0; i < 20; i++) drive(1'b0);
        idle(2);
        send_frame(8'h42, 1'b1, 0, 1'b0);
        idle(2);
        pulse_ready();
        idle(2);

        // overrun: two frames with ready low
        send_frame(8'h11, 1'b1, 0, 1'b0);
        send_frame(8'h22, 1'b1, 0, 1'b0);
        idle(3);
        pulse_ready();
        idle(2);

        // ready exactly on the second completion
        send_frame(8'h11, 1'b1, 0, 1'b0);
        send_frame(8'h22, 1'b1, 0, 1'b1);
        force_edge = 0;
        idle(3);
        pulse_ready();
        idle(2);

        // reset in mid-frame, then 0x5A
        send_frame(8'hFF, 1'b1, 20, 1'b0);
        send_frame(8'h5A, 1'b1, 0, 1'b0);
        idle(2);
        pulse_ready();
        idle(2);

        // randomized traffic
        for (int it = 0; it < 40; it++) begin
            int kind;
            ready_mode = int'($urandom_range(0, 2));
            kind = int'($urandom_range(0, 9));
            if (kind == 0) begin
                glitch(int'($urandom_range(1, OS / 2)));
            end else if (kind == 1) begin
                send_frame(8'($urandom), 1'b0, 0, 1'b0);
                for (int i = 0; i < int'($urandom_range(0, 10)); i++) drive(1'b0);
                idle(int'($urandom_range(1, 3)));
            end else begin
                send_frame(8'($urandom), 1'b1, 0, 1'b0);
                idle(int'($urandom_range(0, 3)));
            end
        end

        ready_mode = 1;
        idle(LAT + 10);
        done = 1'b1;
        idle(3);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
